// File: rtl/asp_pkg.sv
// Shared definitions for the authenticated secure link engine.
//   tx_state_t  : transmit FSM states
//   fold_xor    : XOR-folds a vector into tag-width slices
//   compute_tag : keyed tag = fold(data) ^ fold(key)
//   FrameTagLsb : tag occupies the low bits of a frame, data sits directly above it
package asp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait
    } tx_state_t;

    // Upper bounds for the width-generic helpers below.
    localparam int unsigned FoldMax = 512;
    localparam int unsigned TagMax  = 64;

    localparam int unsigned FrameTagLsb = 0;

    // Bit i lands in tag bit (i mod tag_w): identical to XOR-ing all tag_w-wide slices.
    function automatic logic [TagMax-1:0] fold_xor(input logic [FoldMax-1:0] v,
                                                   input int unsigned width,
                                                   input int unsigned tag_w);
        logic [TagMax-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < FoldMax; i++) begin
            if (i < width) begin
                acc[i % tag_w] = acc[i % tag_w] ^ v[i];
            end
        end
        return acc;
    endfunction

    function automatic logic [TagMax-1:0] compute_tag(input logic [FoldMax-1:0] data,
                                                      input int unsigned data_w,
                                                      input logic [FoldMax-1:0] key,
                                                      input int unsigned key_w,
                                                      input int unsigned tag_w);
        return fold_xor(data, data_w, tag_w) ^ fold_xor(key, key_w, tag_w);
    endfunction

endpackage

// File: rtl/asp_link_arq_if.sv
// Host/network signal bundle of asp_link_arq.
//   master : environment side (drives host words, incoming frames, ACKs)
//   slave  : engine side (drives frames, host deliveries, status pulses)
interface asp_link_arq_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8
) ();

    logic                          data_parity_ready_in;
    logic [DATA_SIZE:0]            data_parity_in;
    logic                          host_ready_out;
    logic                          parity_error_out;
    logic                          network_data_ready_out;
    logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_out;
    logic                          network_ACK_in;
    logic                          link_fail_out;
    logic                          network_data_ready_in;
    logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_in;
    logic                          host_data_ready_out;
    logic [DATA_SIZE-1:0]          host_data_out;
    logic                          network_ACK_out;
    logic                          tag_error_out;

    modport master (
        output data_parity_ready_in, data_parity_in, network_ACK_in,
               network_data_ready_in, network_data_tag_in,
        input  host_ready_out, parity_error_out, network_data_ready_out,
               network_data_tag_out, link_fail_out, host_data_ready_out,
               host_data_out, network_ACK_out, tag_error_out
    );

    modport slave (
        input  data_parity_ready_in, data_parity_in, network_ACK_in,
               network_data_ready_in, network_data_tag_in,
        output host_ready_out, parity_error_out, network_data_ready_out,
               network_data_tag_out, link_fail_out, host_data_ready_out,
               host_data_out, network_ACK_out, tag_error_out
    );

endinterface

// File: rtl/asp_tx_fifo.sv
// Transmit frame buffer, DEPTH entries of WIDTH bits, first-word-fall-through head.
//   clk, reset  : clock, asynchronous active-high reset (empties the buffer)
//   push_i      : write push_data_i at the tail (ignored while full)
//   pop_i       : drop the head entry (ignored while empty)
//   head_o      : current head entry
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
module asp_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the address bits match.
    logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/asp_link_arq.sv
// Authenticated secure link engine with stop-and-wait retransmission.
//   clk, reset : clock, asynchronous active-high reset
//   key_in     : runtime key, folded into every tag when used
//   link       : host/network bundle (asp_link_arq_if.slave)
// TX: parity-checked host words are tagged and buffered, then sent one at a time; each frame
// waits for network_ACK_in, is resent on timeout, and is dropped after MAX_RETRY resends.
// RX: incoming frames are re-tagged; matches are delivered and ACKed, mismatches flagged.
module asp_link_arq
    import asp_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8,
    parameter int unsigned KEY_SIZE  = 16,
    parameter int unsigned TX_DEPTH  = 4,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_SIZE-1:0] key_in,
    asp_link_arq_if.slave       link
);

    localparam int unsigned FrameW = DATA_SIZE + TAG_SIZE;
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    tx_state_t         state_q;
    logic [TimerW-1:0] timer_q;
    logic [RetryW-1:0] retry_q;
    logic              net_valid_q, link_fail_q;
    logic [FrameW-1:0] net_frame_q;
    logic              parity_err_q, host_valid_q, ack_out_q, tag_err_q;
    logic [DATA_SIZE-1:0] host_data_q;

    logic              full, empty, accept, parity_ok, push, pop, timeout, retry_max;
    logic [FrameW-1:0] head, push_frame;
    logic [TagMax-1:0] tx_tag_full, rx_tag_full;
    logic              rx_match, unused_tx_tag;
    logic [DATA_SIZE-1:0] tx_data, rx_data;
    logic [TAG_SIZE-1:0]  rx_tag;

    // Host side: even parity over all DATA_SIZE+1 bits.
    assign accept    = link.data_parity_ready_in & ~full;
    assign parity_ok = ~(^link.data_parity_in);
    assign push      = accept & parity_ok;
    assign tx_data   = link.data_parity_in[DATA_SIZE:1];

    assign tx_tag_full = compute_tag(FoldMax'(tx_data), DATA_SIZE, FoldMax'(key_in), KEY_SIZE,
                                     TAG_SIZE);
    assign push_frame  = {tx_data, tx_tag_full[FrameTagLsb +: TAG_SIZE]};
    assign unused_tx_tag = ^tx_tag_full;

    // WAIT counts 1..TIMEOUT; the edge that would reach TIMEOUT is the timeout edge.
    assign timeout   = (timer_q == TimerW'(TIMEOUT - 1));
    assign retry_max = (retry_q == RetryW'(MAX_RETRY));
    assign pop       = (state_q == StWait) &
                       (link.network_ACK_in | (timeout & retry_max));

    asp_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (FrameW)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_frame),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            retry_q     <= '0;
            net_valid_q <= 1'b0;
            net_frame_q <= '0;
            link_fail_q <= 1'b0;
        end else begin
            net_valid_q <= 1'b0;
            net_frame_q <= '0;
            link_fail_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q     <= StSend;
                        net_valid_q <= 1'b1;
                        net_frame_q <= head;
                    end
                end
                StSend: begin
                    state_q <= StWait;
                    timer_q <= '0;
                end
                StWait: begin
                    if (link.network_ACK_in) begin
                        state_q <= StIdle;
                        retry_q <= '0;
                    end else if (timeout) begin
                        if (retry_max) begin
                            state_q     <= StIdle;
                            retry_q     <= '0;
                            link_fail_q <= 1'b1;
                        end else begin
                            state_q     <= StSend;
                            retry_q     <= retry_q + 1'b1;
                            net_valid_q <= 1'b1;
                            net_frame_q <= head;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RX path: the tag is recomputed over the received data with the current key.
    assign rx_data     = link.network_data_tag_in[TAG_SIZE +: DATA_SIZE];
    assign rx_tag      = link.network_data_tag_in[FrameTagLsb +: TAG_SIZE];
    assign rx_tag_full = compute_tag(FoldMax'(rx_data), DATA_SIZE, FoldMax'(key_in), KEY_SIZE,
                                     TAG_SIZE);
    assign rx_match    = (rx_tag_full == TagMax'(rx_tag));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
            host_valid_q <= 1'b0;
            host_data_q  <= '0;
            ack_out_q    <= 1'b0;
            tag_err_q    <= 1'b0;
        end else begin
            parity_err_q <= accept & ~parity_ok;
            host_valid_q <= link.network_data_ready_in & rx_match;
            ack_out_q    <= link.network_data_ready_in & rx_match;
            host_data_q  <= (link.network_data_ready_in & rx_match) ? rx_data : '0;
            tag_err_q    <= link.network_data_ready_in & ~rx_match;
        end
    end

    // Held low while reset is asserted even though the buffer is empty.
    assign link.host_ready_out         = ~full & ~reset;
    assign link.parity_error_out       = parity_err_q;
    assign link.network_data_ready_out = net_valid_q;
    assign link.network_data_tag_out   = net_frame_q;
    assign link.link_fail_out          = link_fail_q;
    assign link.host_data_ready_out    = host_valid_q;
    assign link.host_data_out          = host_data_q;
    assign link.network_ACK_out        = ack_out_q;
    assign link.tag_error_out          = tag_err_q;

endmodule

// File: doc/asp_link_arq.md
# asp_link_arq

Next-generation authenticated secure link engine. It accepts parity-protected words from the host, checks parity and appends a keyed tag, then transmits frames to the network with ACK-based stop-and-wait retransmission out of a parametrised buffer. In parallel it authenticates incoming network frames and delivers them to the host with an ACK. It replaces the fixed single-shot ASP datapath and adds buffering, timeout/retry and a runtime key.

## Interface
- DATA_SIZE, 32, payload width; must be a multiple of TAG_SIZE
- TAG_SIZE, 8, tag width
- KEY_SIZE, 16, key width; must be a multiple of TAG_SIZE
- TX_DEPTH, 4, TX buffer entries; power of two, ≥2
- TIMEOUT, 15, wait cycles before retransmit; ≥1
- MAX_RETRY, 3, retransmissions before the frame is dropped
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- key_in  in  KEY_SIZE  secret key, sampled on use
- data_parity_ready_in  in  1  host word valid
- data_parity_in  in  DATA_SIZE+1  {data, even-parity bit in [0]}
- host_ready_out  out  1  TX buffer not full
- parity_error_out  out  1  one-cycle pulse, host word dropped
- network_data_ready_out  out  1  frame valid, one-cycle pulse
- network_data_tag_out  out  DATA_SIZE+TAG_SIZE  {data, tag}
- network_ACK_in  in  1  ACK for the outstanding frame
- link_fail_out  out  1  one-cycle pulse, frame dropped after retries
- network_data_ready_in  in  1  incoming frame valid
- network_data_tag_in  in  DATA_SIZE+TAG_SIZE  {data, tag}
- host_data_ready_out  out  1  authenticated word valid, one cycle
- host_data_out  out  DATA_SIZE  authenticated payload
- network_ACK_out  out  1  ACK pulse for an accepted incoming frame
- tag_error_out  out  1  one-cycle pulse, incoming frame rejected

## Operation
- Tag function: tag = XOR of all TAG_SIZE slices of the data, XOR the XOR of all TAG_SIZE slices of key_in. This function is purely combinational.
- Host accept: a word is accepted when data_parity_ready_in && host_ready_out.
  - Parity is good when the XOR of all DATA_SIZE+1 bits is 0.
  - On good parity, {data, tag(data)} is written to the buffer tail.
  - On bad parity, nothing is written and parity_error_out pulses.
- TX FSM states: IDLE, SEND, WAIT.
  - IDLE → SEND when the buffer is non-empty.
  - SEND: drive network_data_ready_out=1 with the head frame for exactly one cycle, then go to WAIT with the timer cleared.
  - WAIT, network_ACK_in=1: pop the head, clear the retry count, go to IDLE.
  - WAIT, timer reaches TIMEOUT with retry count < MAX_RETRY: increment the retry count and go to SEND. The same frame is resent.
  - WAIT, timer reaches TIMEOUT with retry count = MAX_RETRY: pop the head, pulse link_fail_out, clear the retry count, go to IDLE.
  - network_ACK_in outside WAIT is ignored.
  - If ACK and timeout occur in the same cycle, ACK wins.
- RX path, independent of TX:
  - On network_data_ready_in, recompute the tag over the incoming data.
  - Match: host_data_ready_out=1, host_data_out=data, network_ACK_out=1.
  - Mismatch: tag_error_out=1 and host_data_ready_out=0.
  - RX and TX events in the same cycle are both serviced.
- Buffer:
  - host_ready_out = !full, derived from registered pointers.
  - A write is not accepted while full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo TX_DEPTH.
  - A count of TX_DEPTH entries is full; a count of 0 is empty.

## Timing
- Reset: all outputs are 0, including host_ready_out while reset is asserted. The FSM goes to IDLE, the buffer is emptied, and counters clear.
- Reset asserted mid-operation discards buffered and in-flight frames. No pulses are emitted.
- After reset deassert, host_ready_out=1 in the first cycle.
- Host word accepted at edge N:
  - The buffer holds it after edge N.
  - parity_error_out is high in cycle N+1.
  - From an empty, idle engine, the FSM is in SEND at N+2 and network_data_ready_out is high in that cycle.
- Retransmit: the frame reappears TIMEOUT+1 cycles after the previous send pulse (WAIT counts 1..TIMEOUT, then SEND).
- RX latency is 1 cycle: an input valid at edge N gives outputs high for cycle N+1. All outputs are registered.

## Structure
- Shared package asp_pkg holds:
  - the tx_state_t enum (IDLE, SEND, WAIT)
  - the tag computation function, parametrised by width
  - frame field offset constants
- Sub-module asp_tx_fifo: TX_DEPTH × (DATA_SIZE+TAG_SIZE) buffer with push/pop, full/empty, asynchronous reset.
- The FSM, parity check and RX path live in the top module.

## Test plan
- Default parameters, key 16'hA5C3, data_parity_in={32'h12345678,1'b1}:
  - network_data_ready_out pulses 2 cycles later with network_data_tag_out=40'h12345678_6E.
  - ACK in WAIT empties the buffer and returns the FSM to IDLE.
- data_parity_in={32'h12345678,1'b0} → parity_error_out is high for 1 cycle, no network frame is sent, and the buffer stays empty.
- No ACK for a frame:
  - It is sent 4 times, spaced 16 cycles apart.
  - link_fail_out pulses at the 4th timeout.
  - The next buffered frame is then sent.
- Five words are pushed back-to-back with no ACK → host_ready_out=0 after the 4th. After one ACK it rises again the next cycle and the 5th word is accepted. Frames are sent in FIFO order.
- RX frame 40'h12345678_6E with key A5C3 → host_data_out=32'h12345678, with host_data_ready_out and network_ACK_out high for 1 cycle. Tag 8'h6F → tag_error_out only.
- reset asserted during WAIT with 3 frames buffered → all outputs 0 immediately. After release, host_ready_out=1 and no frame is sent.
